// File: rtl/vga_sync_palette_core.sv
// vga_sync_palette_core: 640x480@60 VGA sync/blank generator with linear frame address,
// colour-index fetch (external index or optional image ROM) and fixed 8-entry palette.
// Optional feature macro: IMG_ROM_EN (instantiates the 307200x8 image ROM loaded from IMG_FILE).
// Ports:
//   iVGA_CLK, iRST_n         pixel clock, asynchronous active-low reset
//   iSRC_SEL                 1 = iINDEX, 0 = image ROM (ignored without IMG_ROM_EN)
//   iINDEX[7:0]              colour index for the pixel currently on oADDR
//   oADDR[18:0], oX, oY      cycle-0 frame address and active column/row
//   oHS, oVS, oBLANK_n       syncs and blanking, delayed two cycles to line up with RGB
//   oR, oG, oB               palette colour, two cycles after its oADDR
module vga_sync_palette_core #(
  parameter IMG_FILE = "img_data.hex"
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iSRC_SEL,
  input  logic [7:0]  iINDEX,
  output logic [18:0] oADDR,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  output logic        oHS,
  output logic        oVS,
  output logic        oBLANK_n,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB
);
  logic [9:0]  h, v;
  logic        hs_raw, vs_raw, blank_raw;
  logic [1:0]  hs_d, vs_d, blank_d;
  logic [7:0]  idx, src_idx;
  logic [23:0] pal, rgb;
  assign hs_raw    = h >= 10'd96;
  assign vs_raw    = v >= 10'd2;
  assign blank_raw = h >= 10'd144 && h < 10'd784 && v >= 10'd35 && v < 10'd515;
  assign oX        = blank_raw ? h - 10'd144 : 10'd0;
  assign oY        = blank_raw ? v - 10'd35 : 10'd0;
  localparam unused_img_file = IMG_FILE;
`ifdef IMG_ROM_EN
  logic [7:0] rom [307200];
  assign src_idx = iSRC_SEL ? iINDEX : rom[oADDR];
`else
  logic unused_src_sel;
  assign unused_src_sel = iSRC_SEL;
  assign src_idx = iINDEX;
`endif
  always_comb begin
    pal = idx == 8'd1 ? 24'h00FF00 :
          idx == 8'd2 ? 24'h0000FF :
          idx == 8'd3 ? 24'hFF0000 :
          idx == 8'd4 ? 24'hFFFFFF :
          idx == 8'd5 ? 24'hFFFF00 :
          idx == 8'd6 ? 24'h00FFFF :
          idx == 8'd7 ? 24'hFF00FF : 24'h000000;
  end
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h       <= 10'd0;
      v       <= 10'd0;
      oADDR   <= 19'd0;
      hs_d    <= 2'b11;
      vs_d    <= 2'b11;
      blank_d <= 2'b00;
      idx     <= 8'd0;
      rgb     <= 24'd0;
    end else begin
      h <= h == 10'd799 ? 10'd0 : h + 10'd1;
      if (h == 10'd799) v <= v == 10'd524 ? 10'd0 : v + 10'd1;
      // the address restarts inside the combined hsync/vsync window, then counts only visible pixels
      oADDR   <= (!hs_raw && !vs_raw) ? 19'd0 :
                 blank_raw ? (oADDR == 19'd307199 ? 19'd0 : oADDR + 19'd1) : oADDR;
      hs_d    <= {hs_d[0], hs_raw};
      vs_d    <= {vs_d[0], vs_raw};
      blank_d <= {blank_d[0], blank_raw};
      idx     <= src_idx;
      // blank_d[0] becomes blank_d[1] alongside this colour, so gating here blanks the output pixel
      rgb     <= blank_d[0] ? pal : 24'd0;
    end
  end
  assign oHS      = hs_d[1];
  assign oVS      = vs_d[1];
  assign oBLANK_n = blank_d[1];
  assign oR       = rgb[23:16];
  assign oG       = rgb[15:8];
  assign oB       = rgb[7:0];
endmodule

// File: tb/tb_vga_sync_palette_core.sv
// tb_vga_sync_palette_core: randomized self-checking bench against a cycle-count timing model.
module tb_vga_sync_palette_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src_sel = 1'b1;
  logic [7:0]  index = 8'd0;
  logic [18:0] addr;
  logic [9:0]  x, y;
  logic        hs, vs, bl;
  logic [7:0]  r, g, b;
  int          k;
  logic [7:0]  d1, d2;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] pal_tab [8] = '{24'h000000, 24'h00FF00, 24'h0000FF, 24'hFF0000,
                               24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};

  vga_sync_palette_core dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iSRC_SEL(src_sel), .iINDEX(index),
    .oADDR(addr), .oX(x), .oY(y), .oHS(hs), .oVS(vs), .oBLANK_n(bl),
    .oR(r), .oG(g), .oB(b)
  );

  always #20 clk = ~clk;

  function automatic int hh(int c); return c % 800; endfunction
  function automatic int vv(int c); return (c / 800) % 525; endfunction
  function automatic bit act(int c);
    return hh(c) >= 144 && hh(c) < 784 && vv(c) >= 35 && vv(c) < 515;
  endfunction
  function automatic bit e_hs(int c); return c < 2 ? 1'b1 : hh(c - 2) >= 96; endfunction
  function automatic bit e_vs(int c); return c < 2 ? 1'b1 : vv(c - 2) >= 2; endfunction
  function automatic bit e_bl(int c); return c < 2 ? 1'b0 : act(c - 2); endfunction
  function automatic logic [23:0] e_rgb(int c, logic [7:0] i);
    return (c < 2 || !act(c - 2) || i >= 8) ? 24'h0 : pal_tab[i[2:0]];
  endfunction
  // active pixels already presented in this frame, wrapped at one frame
  function automatic int e_addr(int c);
    int rows, cols;
    rows = vv(c) < 35 ? 0 : vv(c) >= 515 ? 480 : vv(c) - 35;
    cols = (vv(c) < 35 || vv(c) >= 515 || hh(c) < 144) ? 0 : hh(c) >= 784 ? 640 : hh(c) - 144;
    return (rows * 640 + cols) % 307200;
  endfunction
  function automatic int e_x(int c); return act(c) ? hh(c) - 144 : 0; endfunction
  function automatic int e_y(int c); return act(c) ? vv(c) - 35 : 0; endfunction

  task automatic tick(input logic [7:0] i);
    index = i;
    @(posedge clk);
    #1;
    d2 = d1;
    d1 = i;
    k++;
  endtask

  task automatic restart;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    d1 = 8'd0;
    d2 = 8'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({hs, vs, bl} !== 3'b110) begin n_err++; $display("FAIL reset_sync got %b want 110", {hs, vs, bl}); end
    n_cmp++;
    if ({r, g, b} !== 24'h0) begin n_err++; $display("FAIL reset_rgb got %h want 000000", {r, g, b}); end
    n_cmp++;
    if (addr !== 19'd0 || x !== 10'd0 || y !== 10'd0) begin
      n_err++; $display("FAIL reset_addr got addr=%0d x=%0d y=%0d want 0", addr, x, y);
    end
    restart();
  endtask

  task automatic test_sync_solid;
    int hs_low = 0, vs_low = 0;
    while (k < 28000) begin
      if (!hs) hs_low++;
      if (!vs) vs_low++;
      n_cmp++;
      if ({hs, vs, bl} !== {e_hs(k), e_vs(k), e_bl(k)}) begin
        n_err++; $display("FAIL sync k=%0d got %b want %b", k, {hs, vs, bl}, {e_hs(k), e_vs(k), e_bl(k)});
      end
      n_cmp++;
      if ({r, g, b} !== 24'h0 || addr !== 19'd0) begin
        n_err++; $display("FAIL blank_region k=%0d rgb=%h addr=%0d want 0", k, {r, g, b}, addr);
      end
      tick(8'd4);
    end
    n_cmp++;
    if (hs_low != 35 * 96) begin n_err++; $display("FAIL hs_low_count got %0d want %0d", hs_low, 35 * 96); end
    n_cmp++;
    if (vs_low != 1600) begin n_err++; $display("FAIL vs_low_count got %0d want 1600", vs_low); end
  endtask

  task automatic test_palette_ramp;
    while (k < 28800) begin
      if (k == 28144) begin
        n_cmp++;
        if (addr !== 19'd0) begin n_err++; $display("FAIL first_addr got %0d want 0", addr); end
      end
      if (k == 28783) begin
        n_cmp++;
        if (addr !== 19'd639 || x !== 10'd639 || y !== 10'd0) begin
          n_err++; $display("FAIL row0_end got addr=%0d x=%0d y=%0d want 639/639/0", addr, x, y);
        end
      end
      n_cmp++;
      if (bl !== (k >= 28146 && k < 28786)) begin
        n_err++; $display("FAIL ramp_blank k=%0d got %b", k, bl);
      end
      n_cmp++;
      if ({r, g, b} !== ((k >= 28146 && k < 28786) ? pal_tab[(k - 28146) % 8] : 24'h0)) begin
        n_err++; $display("FAIL ramp_rgb k=%0d got %h want %h", k, {r, g, b},
                          (k >= 28146 && k < 28786) ? pal_tab[(k - 28146) % 8] : 24'h0);
      end
      tick(act(k) ? 8'((hh(k) - 144) % 8) : 8'd0);
    end
  endtask

  task automatic test_solid_white;
    int bl_high = 0;
    while (k < 30400) begin
      if (bl) bl_high++;
      n_cmp++;
      if ({r, g, b} !== (e_bl(k) ? 24'hFFFFFF : 24'h0)) begin
        n_err++; $display("FAIL white k=%0d got %h blank_n=%b", k, {r, g, b}, bl);
      end
      tick(8'd4);
    end
    n_cmp++;
    if (bl_high != 1280) begin n_err++; $display("FAIL white_blank_count got %0d want 1280", bl_high); end
  endtask

  task automatic test_out_of_range;
    int bl_high = 0;
    while (k < 31200) begin
      if (bl) bl_high++;
      n_cmp++;
      if ({r, g, b} !== 24'h0) begin
        n_err++; $display("FAIL out_of_range k=%0d got %h want 000000 blank_n=%b", k, {r, g, b}, bl);
      end
      tick(hh(k) % 2 == 1 ? 8'd200 : 8'(8 + $urandom_range(247)));
    end
    n_cmp++;
    if (bl_high != 640) begin n_err++; $display("FAIL oor_blank_count got %0d want 640", bl_high); end
  endtask

  task automatic test_random;
    while (k < 100 * 800 + 300) begin
      n_cmp++;
      if ({hs, vs, bl} !== {e_hs(k), e_vs(k), e_bl(k)}) begin
        n_err++; $display("FAIL rnd_sync k=%0d got %b want %b", k, {hs, vs, bl}, {e_hs(k), e_vs(k), e_bl(k)});
      end
      n_cmp++;
      if (addr !== 19'(e_addr(k)) || x !== 10'(e_x(k)) || y !== 10'(e_y(k))) begin
        n_err++; $display("FAIL rnd_addr k=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                          k, addr, x, y, e_addr(k), e_x(k), e_y(k));
      end
      n_cmp++;
      if ({r, g, b} !== e_rgb(k, d2)) begin
        n_err++; $display("FAIL rnd_rgb k=%0d got %h want %h", k, {r, g, b}, e_rgb(k, d2));
      end
      tick(8'($urandom_range(15)));
    end
  endtask

  task automatic test_mid_reset;
    n_cmp++;
    if (bl !== 1'b1 || addr !== 19'(65 * 640 + 156)) begin
      n_err++; $display("FAIL pre_reset got blank_n=%b addr=%0d want 1/%0d", bl, addr, 65 * 640 + 156);
    end
    #4 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hs, vs, bl} !== 3'b110 || {r, g, b} !== 24'h0) begin
      n_err++; $display("FAIL mid_reset_out got sync=%b rgb=%h want 110/000000", {hs, vs, bl}, {r, g, b});
    end
    n_cmp++;
    if (addr !== 19'd0 || x !== 10'd0 || y !== 10'd0) begin
      n_err++; $display("FAIL mid_reset_addr got %0d/%0d/%0d want 0", addr, x, y);
    end
    restart();
    while (k < 1000) begin
      if (k == 1 || k == 2) begin
        n_cmp++;
        if (hs !== (k == 1)) begin n_err++; $display("FAIL hs_restart k=%0d got %b want %b", k, hs, k == 1); end
      end
      n_cmp++;
      if ({hs, vs, bl} !== {e_hs(k), e_vs(k), e_bl(k)} || addr !== 19'(e_addr(k))) begin
        n_err++; $display("FAIL post_reset k=%0d got %b/%0d want %b/%0d", k, {hs, vs, bl}, addr,
                          {e_hs(k), e_vs(k), e_bl(k)}, e_addr(k));
      end
      tick(8'($urandom_range(255)));
    end
  endtask

  initial begin
    test_reset();
    test_sync_solid();
    test_palette_ramp();
    test_solid_white();
    test_out_of_range();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
